// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the pixel/colour pipeline.
interface vga_timing_gen_if;
  logic       screenEnd;
  logic       active;
  logic       hSync;
  logic       vSync;
  logic [9:0] x;
  logic [8:0] y;

  modport master (
    output screenEnd,
    output active,
    output hSync,
    output vSync,
    output x,
    output y
  );

  modport slave (
    input screenEnd,
    input active,
    input hSync,
    input vSync,
    input x,
    input y
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: free-running pixel/line counters with
// zero-latency combinational decodes so sync stays aligned with x/y.
module vga_timing_gen #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic              clk25,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL    = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START   = WIDTH + H_FRONT;
  localparam int HS_END     = WIDTH + H_FRONT + H_SYNC;
  localparam int VS_START   = HEIGHT + V_FRONT;
  localparam int VS_END     = HEIGHT + V_FRONT + V_SYNC;

  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hVisible;
  logic       vVisible;
  logic       inHSync;
  logic       inVSync;

  // Line counter advances only on the last pixel of a line, wrapping at the bottom.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == 10'(H_TOTAL - 1)) begin
      hCount <= '0;
      if (vCount == 10'(V_TOTAL - 1)) begin
        vCount <= '0;
      end else begin
        vCount <= vCount + 10'd1;
      end
    end else begin
      hCount <= hCount + 10'd1;
    end
  end

  assign hVisible = (hCount < 10'(WIDTH));
  assign vVisible = (vCount < 10'(HEIGHT));
  assign inHSync  = (hCount >= 10'(HS_START)) && (hCount < 10'(HS_END));
  assign inVSync  = (vCount >= 10'(VS_START)) && (vCount < 10'(VS_END));

  // Gating with reset keeps the visible flag and frame tick quiet while held in reset,
  // since the zeroed counters would otherwise decode as pixel (0,0).
  assign vga.x         = hCount;
  assign vga.y         = vCount[8:0];
  assign vga.active    = reset && hVisible && vVisible;
  assign vga.hSync     = !(reset && inHSync);
  assign vga.vSync     = !(reset && inVSync);
  assign vga.screenEnd = reset && (hCount == 10'd0) && (vCount == 10'(HEIGHT));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset and line timing, a shrunken
// instance (60x40 total raster) for frame-level timing within a short run.
module tb_vga_timing_gen;

  localparam int SW    = 40;
  localparam int SH    = 30;
  localparam int SHT   = 60;
  localparam int SVT   = 40;
  localparam int SFRAME = 2400;

  logic clk;
  logic rstBig;
  logic rstSmall;
  int   checks   = 0;
  int   failures = 0;

  vga_timing_gen_if bigIf();
  vga_timing_gen_if smallIf();

  vga_timing_gen dutBig (
    .clk25 (clk),
    .reset (rstBig),
    .vga   (bigIf)
  );

  vga_timing_gen #(
    .WIDTH(40), .HEIGHT(30), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
    .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
  ) dutSmall (
    .clk25 (clk),
    .reset (rstSmall),
    .vga   (smallIf)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (5) stepCycle();
    checks++; if (bigIf.active !== 1'b0) begin failures++; $display("[TB] FAIL reset_active: got %b expected 0", bigIf.active); end
    checks++; if (bigIf.hSync !== 1'b1) begin failures++; $display("[TB] FAIL reset_hsync: got %b expected 1", bigIf.hSync); end
    checks++; if (bigIf.vSync !== 1'b1) begin failures++; $display("[TB] FAIL reset_vsync: got %b expected 1", bigIf.vSync); end
    checks++; if (bigIf.screenEnd !== 1'b0) begin failures++; $display("[TB] FAIL reset_screenend: got %b expected 0", bigIf.screenEnd); end
    checks++; if (bigIf.x !== 10'd0 || bigIf.y !== 9'd0) begin failures++; $display("[TB] FAIL reset_xy: got %0d,%0d expected 0,0", bigIf.x, bigIf.y); end
    @(negedge clk);
    rstBig = 1'b1;
    #1;
    checks++; if (bigIf.active !== 1'b1 || bigIf.x !== 10'd0) begin failures++; $display("[TB] FAIL release_pixel0: got active=%b x=%0d expected active=1 x=0", bigIf.active, bigIf.x); end
    stepCycle();
    checks++; if (bigIf.x !== 10'd1 || bigIf.y !== 9'd0 || bigIf.active !== 1'b1) begin failures++; $display("[TB] FAIL release_next: got x=%0d y=%0d active=%b expected x=1 y=0 active=1", bigIf.x, bigIf.y, bigIf.active); end
  endtask

  task automatic test_line();
    int  hLow;
    logic expAct;
    logic expHs;
    @(negedge clk); rstBig = 1'b0;
    @(negedge clk); rstBig = 1'b1;
    #1;
    hLow = 0;
    for (int i = 0; i < 800; i++) begin
      expAct = (i < 640);
      expHs  = !(i >= 656 && i < 752);
      checks++; if (bigIf.x !== 10'(i) || bigIf.y !== 9'd0) begin failures++; $display("[TB] FAIL line_xy: got %0d,%0d expected %0d,0", bigIf.x, bigIf.y, i); end
      checks++; if (bigIf.active !== expAct) begin failures++; $display("[TB] FAIL line_active x=%0d: got %b expected %b", i, bigIf.active, expAct); end
      checks++; if (bigIf.hSync !== expHs) begin failures++; $display("[TB] FAIL line_hsync x=%0d: got %b expected %b", i, bigIf.hSync, expHs); end
      checks++; if (bigIf.vSync !== 1'b1 || bigIf.screenEnd !== 1'b0) begin failures++; $display("[TB] FAIL line_quiet x=%0d: got vSync=%b screenEnd=%b expected 1,0", i, bigIf.vSync, bigIf.screenEnd); end
      if (bigIf.hSync === 1'b0) hLow++;
      stepCycle();
    end
    checks++; if (bigIf.x !== 10'd0 || bigIf.y !== 9'd1) begin failures++; $display("[TB] FAIL line_wrap: got %0d,%0d expected 0,1", bigIf.x, bigIf.y); end
    checks++; if (hLow !== 96) begin failures++; $display("[TB] FAIL line_hsync_width: got %0d expected 96", hLow); end
  endtask

  task automatic test_async_reset();
    repeat (123) stepCycle();
    checks++; if (bigIf.x !== 10'd123 || bigIf.y !== 9'd1) begin failures++; $display("[TB] FAIL async_pre: got %0d,%0d expected 123,1", bigIf.x, bigIf.y); end
    @(negedge clk);
    #5;
    rstBig = 1'b0;
    #1;
    checks++; if (bigIf.x !== 10'd0 || bigIf.y !== 9'd0 || bigIf.active !== 1'b0) begin failures++; $display("[TB] FAIL async_now: got x=%0d y=%0d active=%b expected 0,0,0", bigIf.x, bigIf.y, bigIf.active); end
    stepCycle();
    @(negedge clk);
    rstBig = 1'b1;
    #1;
    checks++; if (bigIf.x !== 10'd0 || bigIf.active !== 1'b1) begin failures++; $display("[TB] FAIL async_release: got x=%0d active=%b expected 0,1", bigIf.x, bigIf.active); end
  endtask

  task automatic test_frame();
    int hx, vy, vLow, actCnt, seCnt, seFirst, seSecond;
    logic expAct, expVs;
    @(negedge clk); rstSmall = 1'b0;
    @(negedge clk); rstSmall = 1'b1;
    #1;
    vLow = 0; actCnt = 0; seCnt = 0; seFirst = -1; seSecond = -1;
    for (int c = 0; c < 2 * SFRAME; c++) begin
      hx = c % SHT;
      vy = (c / SHT) % SVT;
      expAct = (hx < SW) && (vy < SH);
      expVs  = !(vy >= 33 && vy < 35);
      checks++; if (smallIf.x !== 10'(hx) || smallIf.y !== 9'(vy)) begin failures++; $display("[TB] FAIL frame_xy c=%0d: got %0d,%0d expected %0d,%0d", c, smallIf.x, smallIf.y, hx, vy); end
      checks++; if (smallIf.active !== expAct) begin failures++; $display("[TB] FAIL frame_active c=%0d: got %b expected %b", c, smallIf.active, expAct); end
      checks++; if (smallIf.vSync !== expVs) begin failures++; $display("[TB] FAIL frame_vsync c=%0d: got %b expected %b", c, smallIf.vSync, expVs); end
      if (c < SFRAME && smallIf.vSync === 1'b0) vLow++;
      if (c < SFRAME && smallIf.active === 1'b1) actCnt++;
      if (smallIf.screenEnd === 1'b1) begin
        seCnt++;
        if (seFirst < 0) seFirst = c; else seSecond = c;
        checks++; if (smallIf.x !== 10'd0 || smallIf.y !== 9'd30) begin failures++; $display("[TB] FAIL frame_se_pos: got %0d,%0d expected 0,30", smallIf.x, smallIf.y); end
      end
      stepCycle();
    end
    checks++; if (vLow !== 2 * SHT) begin failures++; $display("[TB] FAIL frame_vsync_width: got %0d expected %0d", vLow, 2 * SHT); end
    checks++; if (actCnt !== SW * SH) begin failures++; $display("[TB] FAIL frame_active_count: got %0d expected %0d", actCnt, SW * SH); end
    checks++; if (seCnt !== 2) begin failures++; $display("[TB] FAIL frame_se_count: got %0d expected 2", seCnt); end
    checks++; if (seFirst !== SH * SHT) begin failures++; $display("[TB] FAIL frame_se_first: got %0d expected %0d", seFirst, SH * SHT); end
    checks++; if (seSecond - seFirst !== SFRAME) begin failures++; $display("[TB] FAIL frame_se_period: got %0d expected %0d", seSecond - seFirst, SFRAME); end
  endtask

  task automatic test_bottom_wrap();
    @(negedge clk); rstSmall = 1'b0;
    @(negedge clk); rstSmall = 1'b1;
    #1;
    repeat (SFRAME - 1) stepCycle();
    checks++; if (smallIf.x !== 10'd59 || smallIf.y !== 9'd39 || smallIf.active !== 1'b0) begin failures++; $display("[TB] FAIL wrap_last: got x=%0d y=%0d active=%b expected 59,39,0", smallIf.x, smallIf.y, smallIf.active); end
    stepCycle();
    checks++; if (smallIf.x !== 10'd0 || smallIf.y !== 9'd0 || smallIf.active !== 1'b1) begin failures++; $display("[TB] FAIL wrap_first: got x=%0d y=%0d active=%b expected 0,0,1", smallIf.x, smallIf.y, smallIf.active); end
  endtask

  task automatic test_mid_frame_reset();
    int n;
    @(negedge clk); rstSmall = 1'b0;
    @(negedge clk); rstSmall = 1'b1;
    #1;
    repeat (20 * SHT + 46) stepCycle();
    checks++; if (smallIf.x !== 10'd46 || smallIf.y !== 9'd20 || smallIf.hSync !== 1'b0) begin failures++; $display("[TB] FAIL mid_pre: got x=%0d y=%0d hSync=%b expected 46,20,0", smallIf.x, smallIf.y, smallIf.hSync); end
    @(negedge clk);
    #5;
    rstSmall = 1'b0;
    #1;
    checks++; if (smallIf.x !== 10'd0 || smallIf.y !== 9'd0) begin failures++; $display("[TB] FAIL mid_xy: got %0d,%0d expected 0,0", smallIf.x, smallIf.y); end
    checks++; if (smallIf.hSync !== 1'b1 || smallIf.vSync !== 1'b1 || smallIf.active !== 1'b0) begin failures++; $display("[TB] FAIL mid_outs: got hSync=%b vSync=%b active=%b expected 1,1,0", smallIf.hSync, smallIf.vSync, smallIf.active); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (smallIf.screenEnd !== 1'b0) begin failures++; $display("[TB] FAIL mid_hold_se: got %b expected 0", smallIf.screenEnd); end
      stepCycle();
    end
    @(negedge clk);
    rstSmall = 1'b1;
    #1;
    n = 0;
    while (smallIf.screenEnd !== 1'b1 && n < 5000) begin
      stepCycle();
      n++;
    end
    checks++; if (n !== SH * SHT) begin failures++; $display("[TB] FAIL mid_se_delay: got %0d expected %0d", n, SH * SHT); end
    checks++; if (smallIf.y !== 9'd30 || smallIf.x !== 10'd0) begin failures++; $display("[TB] FAIL mid_se_pos: got %0d,%0d expected 0,30", smallIf.x, smallIf.y); end
  endtask

  initial begin
    rstBig   = 1'b0;
    rstSmall = 1'b0;
    $display("[TB] starting vga_timing_gen bench");
    test_reset();
    test_line();
    test_async_reset();
    test_frame();
    test_bottom_wrap();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
